mem_bus_arbiter: RTL and testbench

Shares the CPU's single memory bus (ROM/RAM address, data and read/write strobes) between the CPU control path and a DMA/program-loader port. CPU has fixed priority, with a bounded-hold fairness rule for DMA. Handoff between masters always passes through a one-cycle bus turnaround. CPU handoff happens only while the CPU is not inside a locked instruction phase. The block sits between the CPU's bus-driving logic and the memory, and its `cpu_wait` output gates the CPU's `ena`.

---
 rtl/mem_bus_arbiter.sv | 178 +++++++++++++++++
 tb/tb_mem_bus_arbiter.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter
// Shares the single memory bus between the CPU control path and a DMA /
// program-loader port. The CPU has fixed priority. Either owner is forced off
// the bus after MAX_HOLD contested cycles. A locked CPU phase defers that
// handoff until cpu_lock drops. Every change of owner passes through one dead
// TURN cycle.
//
// Ports
//   clk1, rst          clock (posedge) and asynchronous active-high reset
//   cpu_req/cpu_lock   CPU bus request / indivisible-phase flag
//   cpu_rd/wr/addr/wdata  CPU bus signals
//   dma_req            DMA bus request
//   dma_rd/wr/addr/wdata  DMA bus signals
//   cpu_gnt/dma_gnt    registered grants (one-hot or zero)
//   cpu_wait           cpu_req & ~cpu_gnt, used to stall the CPU's ena
//   mem_rd/wr/addr/wdata  owner's signals gated by its grant, zero otherwise
module mem_bus_arbiter #(
  parameter int AW       = 13,
  parameter int DW       = 8,
  parameter int MAX_HOLD = 16
) (
  input  logic          clk1,
  input  logic          rst,
  input  logic          cpu_req,
  input  logic          cpu_lock,
  input  logic          cpu_rd,
  input  logic          cpu_wr,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  input  logic          dma_req,
  input  logic          dma_rd,
  input  logic          dma_wr,
  input  logic [AW-1:0] dma_addr,
  input  logic [DW-1:0] dma_wdata,
  output logic          cpu_gnt,
  output logic          dma_gnt,
  output logic          cpu_wait,
  output logic          mem_rd,
  output logic          mem_wr,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata
);

  localparam int            HW      = $clog2(MAX_HOLD + 1);
  localparam logic [HW-1:0] HoldMax = HW'(MAX_HOLD);
  localparam logic          OwnCpu  = 1'b0;
  localparam logic          OwnDma  = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CPU  = 2'b01,
    DMA  = 2'b10,
    TURN = 2'b11
  } state_e;

  state_e        state_q, state_d;
  logic          next_own_q, next_own_d;
  logic [HW-1:0] hold_cnt_q, hold_cnt_d;
  logic          cpu_gnt_q, dma_gnt_q;
  logic          hold_at_max;

  assign hold_at_max = (hold_cnt_q == HoldMax);

  // State, owner preference, hold counter and grant registers. The grants
  // get their own flops, loaded from the next state, so they come straight
  // off a flop rather than from a state decode.
  always_ff @(posedge clk1 or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      next_own_q <= OwnCpu;
      hold_cnt_q <= '0;
      cpu_gnt_q  <= 1'b0;
      dma_gnt_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      next_own_q <= next_own_d;
      hold_cnt_q <= hold_cnt_d;
      cpu_gnt_q  <= (state_d == CPU);
      dma_gnt_q  <= (state_d == DMA);
    end
  end

  // Next-state logic. A limit handoff is decided in the cycle in which the
  // counter already shows MAX_HOLD, so the owner sees MAX_HOLD counted
  // contested cycles plus that deciding cycle. On a voluntary CPU release
  // with no DMA waiting, the CPU keeps the preference for the TURN cycle.
  always_comb begin
    state_d    = state_q;
    next_own_d = next_own_q;
    case (state_q)
      IDLE: begin
        if (cpu_req) begin
          state_d = CPU;
        end else if (dma_req) begin
          state_d = DMA;
        end
      end
      CPU: begin
        if (!cpu_req) begin
          state_d    = TURN;
          next_own_d = dma_req ? OwnDma : OwnCpu;
        end else if (hold_at_max && dma_req && !cpu_lock) begin
          state_d    = TURN;
          next_own_d = OwnDma;
        end
      end
      DMA: begin
        if (!dma_req) begin
          state_d    = TURN;
          next_own_d = OwnCpu;
        end else if (hold_at_max && cpu_req) begin
          state_d    = TURN;
          next_own_d = OwnCpu;
        end
      end
      TURN: begin
        if (next_own_q == OwnCpu) begin
          if (cpu_req) begin
            state_d = CPU;
          end else if (dma_req) begin
            state_d = DMA;
          end else begin
            state_d = IDLE;
          end
        end else begin
          if (dma_req) begin
            state_d = DMA;
          end else if (cpu_req) begin
            state_d = CPU;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Hold counter: cleared whenever a new owner takes the bus. Otherwise it
  // counts the owner's cycles with the other master requesting and saturates
  // at MAX_HOLD. It is only held, never cleared, when the other request
  // drops for a while.
  always_comb begin
    hold_cnt_d = hold_cnt_q;
    if ((state_d == CPU || state_d == DMA) && (state_d != state_q)) begin
      hold_cnt_d = '0;
    end else if (state_q == CPU && dma_req && !hold_at_max) begin
      hold_cnt_d = hold_cnt_q + HW'(1);
    end else if (state_q == DMA && cpu_req && !hold_at_max) begin
      hold_cnt_d = hold_cnt_q + HW'(1);
    end
  end

  assign cpu_gnt  = cpu_gnt_q;
  assign dma_gnt  = dma_gnt_q;
  assign cpu_wait = cpu_req & ~cpu_gnt_q;

  // Bus mux: the owner's signals, gated by its registered grant. rd and wr
  // both high from the owner are passed through unchanged.
  always_comb begin
    mem_rd    = 1'b0;
    mem_wr    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (cpu_gnt_q) begin
      mem_rd    = cpu_rd;
      mem_wr    = cpu_wr;
      mem_addr  = cpu_addr;
      mem_wdata = cpu_wdata;
    end else if (dma_gnt_q) begin
      mem_rd    = dma_rd;
      mem_wr    = dma_wr;
      mem_addr  = dma_addr;
      mem_wdata = dma_wdata;
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb_mem_bus_arbiter
// Directed table of per-cycle vectors for mem_bus_arbiter (MAX_HOLD = 4),
// followed by hand-written sequences for locked preemption, the cpu_wait
// length on a DMA-to-CPU handoff, and reset in the middle of a DMA write.
module tb_mem_bus_arbiter;

  localparam int AW = 13;
  localparam int DW = 8;
  localparam logic [AW-1:0] CpuAddr  = 13'h0AA5;
  localparam logic [DW-1:0] CpuWdata = 8'h3C;
  localparam logic [AW-1:0] DmaAddr  = 13'h1F02;
  localparam logic [DW-1:0] DmaWdata = 8'hC5;

  logic          clk1;
  logic          rst;
  logic          cpu_req, cpu_lock, cpu_rd, cpu_wr;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata;
  logic          dma_req, dma_rd, dma_wr;
  logic [AW-1:0] dma_addr;
  logic [DW-1:0] dma_wdata;
  logic          cpu_gnt, dma_gnt, cpu_wait;
  logic          mem_rd, mem_wr;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;

  int compared   = 0;
  int mismatched = 0;

  typedef struct {
    string nm;
    bit rst, cq, cl, crd, cwr, dq, drd, dwr;
    bit eCg, eDg, eCw, eRd, eWr;
  } vec_t;

  vec_t vecs[$];

  mem_bus_arbiter #(.AW(AW), .DW(DW), .MAX_HOLD(4)) dut (
    .clk1(clk1), .rst(rst),
    .cpu_req(cpu_req), .cpu_lock(cpu_lock), .cpu_rd(cpu_rd), .cpu_wr(cpu_wr),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .dma_req(dma_req), .dma_rd(dma_rd), .dma_wr(dma_wr),
    .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .cpu_gnt(cpu_gnt), .dma_gnt(dma_gnt), .cpu_wait(cpu_wait),
    .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata)
  );

  // Free-running clock, posedges at 5, 15, 25, ...
  initial begin
    clk1 = 1'b0;
    forever #5 clk1 = ~clk1;
  end

  // Absolute time limit so the run always ends.
  initial begin
    #200000;
    $display("[TB] FAIL timeout: simulation still running at %0t, required finish", $time);
    $fatal(1, "[TB] timeout");
  end

  function automatic vec_t mk(string nm, bit r, bit cq, bit cl, bit crd, bit cwr,
                              bit dq, bit drd, bit dwr,
                              bit eCg, bit eDg, bit eCw, bit eRd, bit eWr);
    vec_t v;
    v.nm = nm; v.rst = r; v.cq = cq; v.cl = cl; v.crd = crd; v.cwr = cwr;
    v.dq = dq; v.drd = drd; v.dwr = dwr;
    v.eCg = eCg; v.eDg = eDg; v.eCw = eCw; v.eRd = eRd; v.eWr = eWr;
    return v;
  endfunction

  task automatic checkOutput(input string nm, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  // Drive one cycle's inputs half a period away from the active edge; outputs
  // are then sampled 1 time unit later, before the next posedge.
  task automatic setIn(input bit r, input bit cq, input bit cl, input bit crd, input bit cwr,
                       input bit dq, input bit drd, input bit dwr);
    @(negedge clk1);
    rst = r; cpu_req = cq; cpu_lock = cl; cpu_rd = crd; cpu_wr = cwr;
    dma_req = dq; dma_rd = drd; dma_wr = dwr;
    #1;
  endtask

  task automatic applyStimulus(input vec_t v);
    logic [AW-1:0] eAddr;
    logic [DW-1:0] eData;
    setIn(v.rst, v.cq, v.cl, v.crd, v.cwr, v.dq, v.drd, v.dwr);
    eAddr = v.eCg ? CpuAddr  : (v.eDg ? DmaAddr  : '0);
    eData = v.eCg ? CpuWdata : (v.eDg ? DmaWdata : '0);
    checkOutput({v.nm, ".cpu_gnt"},   32'(cpu_gnt),   32'(v.eCg));
    checkOutput({v.nm, ".dma_gnt"},   32'(dma_gnt),   32'(v.eDg));
    checkOutput({v.nm, ".cpu_wait"},  32'(cpu_wait),  32'(v.eCw));
    checkOutput({v.nm, ".mem_rd"},    32'(mem_rd),    32'(v.eRd));
    checkOutput({v.nm, ".mem_wr"},    32'(mem_wr),    32'(v.eWr));
    checkOutput({v.nm, ".mem_addr"},  32'(mem_addr),  32'(eAddr));
    checkOutput({v.nm, ".mem_wdata"}, 32'(mem_wdata), 32'(eData));
  endtask

  task automatic doReset();
    setIn(1, 0, 0, 0, 0, 0, 0, 0);
    setIn(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    int waits;
    rst = 1'b1;
    cpu_req = 0; cpu_lock = 0; cpu_rd = 0; cpu_wr = 0;
    dma_req = 0; dma_rd = 0; dma_wr = 0;
    cpu_addr = CpuAddr; cpu_wdata = CpuWdata;
    dma_addr = DmaAddr; dma_wdata = DmaWdata;

    //                 name        rst cq cl crd cwr dq drd dwr  cg dg cw rd wr
    vecs.push_back(mk("rstHold",   1, 1, 0, 1, 0,  0, 0, 0,    0, 0, 1, 0, 0));
    vecs.push_back(mk("rstRel",    0, 1, 0, 1, 0,  0, 0, 0,    0, 0, 1, 0, 0));
    vecs.push_back(mk("cpuGnt",    0, 1, 0, 1, 0,  0, 0, 0,    1, 0, 0, 1, 0));
    vecs.push_back(mk("cont1",     0, 1, 0, 0, 1,  1, 0, 1,    1, 0, 0, 0, 1));
    vecs.push_back(mk("cont2",     0, 1, 0, 0, 1,  1, 0, 1,    1, 0, 0, 0, 1));
    vecs.push_back(mk("cont3",     0, 1, 0, 0, 1,  1, 0, 1,    1, 0, 0, 0, 1));
    vecs.push_back(mk("cont4",     0, 1, 0, 0, 1,  1, 0, 1,    1, 0, 0, 0, 1));
    vecs.push_back(mk("contLast",  0, 1, 0, 0, 1,  1, 0, 1,    1, 0, 0, 0, 1));
    vecs.push_back(mk("turnA",     0, 1, 0, 0, 1,  1, 0, 1,    0, 0, 1, 0, 0));
    vecs.push_back(mk("dmaGnt",    0, 0, 0, 0, 0,  1, 0, 1,    0, 1, 0, 0, 1));
    vecs.push_back(mk("dmaRd",     0, 0, 0, 0, 0,  1, 1, 0,    0, 1, 0, 1, 0));
    vecs.push_back(mk("dmaRel",    0, 0, 0, 0, 0,  0, 0, 0,    0, 1, 0, 0, 0));
    vecs.push_back(mk("turnB",     0, 0, 0, 0, 0,  0, 0, 0,    0, 0, 0, 0, 0));
    vecs.push_back(mk("idleDma",   0, 0, 0, 0, 0,  1, 0, 1,    0, 0, 0, 0, 0));
    vecs.push_back(mk("dmaWr",     0, 0, 0, 0, 0,  1, 0, 1,    0, 1, 0, 0, 1));
    vecs.push_back(mk("dmaRel2",   0, 0, 0, 0, 0,  0, 0, 0,    0, 1, 0, 0, 0));
    vecs.push_back(mk("turnC",     0, 0, 0, 0, 0,  0, 0, 0,    0, 0, 0, 0, 0));
    vecs.push_back(mk("idleBoth",  0, 1, 0, 0, 0,  1, 0, 0,    0, 0, 1, 0, 0));
    vecs.push_back(mk("cpuWins",   0, 1, 0, 1, 0,  1, 0, 0,    1, 0, 0, 1, 0));
    vecs.push_back(mk("rdWrBoth",  0, 1, 0, 1, 1,  0, 0, 0,    1, 0, 0, 1, 1));
    vecs.push_back(mk("cpuRel",    0, 0, 0, 0, 0,  0, 0, 0,    1, 0, 0, 0, 0));
    vecs.push_back(mk("turnD",     0, 0, 0, 0, 0,  1, 0, 0,    0, 0, 0, 0, 0));
    vecs.push_back(mk("dmaAfter",  0, 0, 0, 0, 0,  1, 1, 0,    0, 1, 0, 1, 0));

    foreach (vecs[i]) applyStimulus(vecs[i]);

    // Limit reached while locked: CPU keeps the bus for 3 extra cycles, then
    // hands off on the first unlocked cycle through one TURN cycle.
    doReset();
    setIn(0, 1, 0, 0, 0, 0, 0, 0);
    setIn(0, 1, 0, 0, 1, 1, 0, 1);
    checkOutput("lkGnt0", 32'(cpu_gnt), 32'd1);
    for (int i = 0; i < 3; i++) begin
      setIn(0, 1, 0, 0, 1, 1, 0, 1);
      checkOutput($sformatf("lkCount%0d", i), 32'(cpu_gnt), 32'd1);
    end
    for (int i = 0; i < 3; i++) begin
      setIn(0, 1, 1, 0, 1, 1, 0, 1);
      checkOutput($sformatf("lkHeld%0d", i), 32'(cpu_gnt), 32'd1);
      checkOutput($sformatf("lkHeldWr%0d", i), 32'(mem_wr), 32'd1);
    end
    setIn(0, 1, 0, 0, 1, 1, 0, 1);
    checkOutput("lkUnlock", 32'(cpu_gnt), 32'd1);
    setIn(0, 1, 0, 0, 1, 1, 0, 1);
    checkOutput("lkTurnCg", 32'(cpu_gnt), 32'd0);
    checkOutput("lkTurnDg", 32'(dma_gnt), 32'd0);
    checkOutput("lkTurnWr", 32'(mem_wr), 32'd0);
    checkOutput("lkTurnAddr", 32'(mem_addr), 32'd0);
    setIn(0, 1, 0, 0, 0, 1, 0, 1);
    checkOutput("lkDmaGnt", 32'(dma_gnt), 32'd1);
    checkOutput("lkDmaWr", 32'(mem_wr), 32'd1);
    checkOutput("lkDmaAddr", 32'(mem_addr), 32'(DmaAddr));

    // DMA owns, cpu_req rises, dma_req drops next cycle: cpu_wait lasts
    // exactly 3 cycles (two DMA cycles plus TURN) before cpu_gnt.
    doReset();
    setIn(0, 0, 0, 0, 0, 1, 0, 0);
    setIn(0, 0, 0, 0, 0, 1, 0, 1);
    checkOutput("hoDmaGnt", 32'(dma_gnt), 32'd1);
    waits = 0;
    for (int i = 0; i < 10; i++) begin
      setIn(0, 1, 0, 0, 0, (i == 0), 0, 0);
      if (cpu_gnt) break;
      if (cpu_wait) waits++;
    end
    checkOutput("hoCpuGnt", 32'(cpu_gnt), 32'd1);
    checkOutput("hoWaitCycles", 32'(waits), 32'd3);

    // Reset in the middle of a DMA write drops everything at once.
    doReset();
    setIn(0, 0, 0, 0, 0, 1, 0, 1);
    setIn(0, 1, 0, 0, 0, 1, 0, 1);
    checkOutput("rmWrBefore", 32'(mem_wr), 32'd1);
    setIn(0, 1, 0, 0, 0, 1, 0, 1);
    checkOutput("rmHoldBefore", 32'(dut.hold_cnt_q), 32'd1);
    #1 rst = 1'b1;
    #1;
    checkOutput("rmWr", 32'(mem_wr), 32'd0);
    checkOutput("rmDmaGnt", 32'(dma_gnt), 32'd0);
    checkOutput("rmAddr", 32'(mem_addr), 32'd0);
    checkOutput("rmCpuWait", 32'(cpu_wait), 32'd1);
    checkOutput("rmState", 32'(dut.state_q), 32'd0);
    checkOutput("rmHold", 32'(dut.hold_cnt_q), 32'd0);
    setIn(0, 0, 0, 0, 0, 0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
